mux8x1_serializer: RTL
======================

# mux8x1_serializer

Sequencing stage that sits directly upstream of the 8:1 bit multiplexer and turns it into a parallel-to-serial converter. It accepts an 8-bit word on a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all eight positions, one bit per accepted output beat. Per-bit valid/last flags and downstream backpressure are provided, so the mux output can feed a serial link or shift register directly.

## Interface
- `GAP`, 0: idle cycles inserted after each word before `in_ready` re-asserts; range 0–15.
- `MSB_FIRST`, 0: 0 = select order 0→7; 1 = select order 7→0.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  8  word to serialize.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `out_ready`  input  1  downstream accepts the current bit.
- `mux_in`  output  8  held word; drives the mux data inputs.
- `mux_sel`  output  3  drives the mux select.
- `bit_valid`  output  1  the mux output is a valid serial bit this cycle.
- `bit_last`  output  1  current beat is the final beat of the word.
- `parity`  output  1  parity beat value (see Configuration).
- `busy`  output  1  state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, PARITY (macro only), GAP.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: load `mux_in`←`in_data`, set `mux_sel` to the start index (0, or 7 if `MSB_FIRST`), go to SHIFT.
- SHIFT:
  - `bit_valid`=1.
  - A beat is accepted when `bit_valid`&`out_ready`.
  - On acceptance, `mux_sel` steps ±1.
  - `bit_last`=1 while `mux_sel` equals the end index (7, or 0 if `MSB_FIRST`) and the parity phase is disabled.
  - With `out_ready`=0, all outputs hold.
- After the final data beat is accepted, go to PARITY if enabled; otherwise:
  - `GAP`>0: go to GAP.
  - `GAP`=0: go to IDLE.
- GAP: a 4-bit counter loads `GAP-1`, decrements each cycle, and returns to IDLE at 0. `bit_valid`=0 and `in_ready`=0 throughout.
- Back-to-back transfer, `GAP`=0 only:
  - `in_ready` also asserts during the final beat of SHIFT (or PARITY) when `out_ready`=1.
  - A word accepted then loads immediately and SHIFT restarts at the start index; there is no idle cycle.
  - This creates a combinational path `out_ready`→`in_ready`.
- `mux_sel` counter wraps modulo 8 and is never observable out of range.
- `mux_in` changes only on load.
- Reset mid-word aborts the word. No partial bits are emitted afterwards.

## Timing
- Reset values:
  - state IDLE.
  - `mux_in`=0, `mux_sel`=0.
  - `bit_valid`=0, `bit_last`=0, `parity`=0, `busy`=0.
  - `in_ready`=0 while `rst`=1, and 1 in the first cycle after release.
- Load latency: the handshake at edge N gives the first `bit_valid` in cycle N+1 with the start `mux_sel`.
- `bit_valid`, `bit_last`, `mux_sel`, `mux_in` and `busy` are registered. `in_ready` is decoded from state (plus `out_ready` in the back-to-back case).
- Throughput, no backpressure:
  - `GAP`=0: 8 beats per 8 cycles (9 with parity).
  - Otherwise: 8 (+1) + `GAP` + 1 cycles per word.
- `in_valid` during SHIFT (back-to-back case excepted) is ignored; upstream must hold it until `in_ready`.

## Configuration
- Macro `MUX8X1_SERIALIZER_PARITY_EN`.
- Defined:
  - After data beat 7 is accepted, enter PARITY for one beat with `bit_valid`=1 and `bit_last`=1.
  - `parity` = XOR of `mux_in` (even parity). Downstream selects `parity` instead of the mux output while in the PARITY state; the beat obeys `out_ready`.
  - `bit_last` is 0 on data beats.
- Undefined: no PARITY state, `parity` tied 0, `bit_last` on data beat 7.

## Test plan
- Reset then load 0xA5, `MSB_FIRST`=0, `out_ready`=1 → `mux_sel` 0..7 on 8 consecutive cycles; sampled mux output 1,0,1,0,0,1,0,1; `bit_last` only at sel 7; `busy` falls the cycle after.
- Load 0x3C with `out_ready` toggling 1,0 every cycle → each sel held 2 cycles; the 8 bits are delivered in order over 16 cycles with no loss or duplication.
- `GAP`=0: words 0xFF then 0x00 back to back → `in_ready`=1 on the last beat; 16 contiguous `bit_valid` cycles; `mux_in` switches exactly after the sel 7 beat.
- `GAP`=3, `MSB_FIRST`=1, load 0x81 → sel 7..0; `in_ready` low for 3 cycles after the last beat, then high.
- `rst` asserted at sel 4 → next cycle IDLE, `bit_valid`=0, `mux_sel`=0, `mux_in`=0; a new word then starts at sel 0.
- With `MUX8X1_SERIALIZER_PARITY_EN`, load 0x07 → 8 data beats with `bit_last`=0, then a 9th beat with `parity`=1 and `bit_last`=1.

Source files
------------

// File: rtl/mux8x1_serializer.sv
// mux8x1_serializer
// Sequencer that sits in front of an 8:1 bit mux and turns it into a
// parallel-to-serial converter. It accepts a word on a valid/ready handshake,
// holds it on the mux data inputs, and steps the mux select one position per
// accepted output beat. Downstream can apply backpressure with out_ready.
//
// Optional feature: define MUX8X1_SERIALIZER_PARITY_EN to append one
// even-parity beat after the eight data beats.
//
// state    | meaning
// S_IDLE   | no word held; in_ready high
// S_SHIFT  | presenting data beats; mux_sel walks start -> end index
// S_PARITY | presenting the parity beat (only with the parity macro)
// S_GAP    | post-word idle cycles; in_ready low while gap_cnt runs down

module mux8x1_serializer #(
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic [7:0] mux_in,
  output logic [2:0] mux_sel,
  output logic       bit_valid,
  output logic       bit_last,
  output logic       parity,
  output logic       busy
);

  localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] SEL_END   = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef MUX8X1_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd3
  } state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] data_nxt;
  logic [2:0] sel_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       word_done;
  logic       bit_valid_nxt;
  logic       bit_last_nxt;
  logic       busy_nxt;

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mux_in    <= 8'h00;
      mux_sel   <= 3'd0;
      gap_cnt   <= 4'd0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mux_in    <= data_nxt;
      mux_sel   <= sel_nxt;
      gap_cnt   <= gap_cnt_nxt;
      bit_valid <= bit_valid_nxt;
      bit_last  <= bit_last_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic. word_done marks the cycle the final beat of a word is
  // accepted; the tail handling after the case is shared by SHIFT and PARITY.
  always_comb begin
    state_nxt   = state;
    data_nxt    = mux_in;
    sel_nxt     = mux_sel;
    gap_cnt_nxt = gap_cnt;
    word_done   = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          data_nxt  = in_data;
          sel_nxt   = SEL_START;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (out_ready) begin
          if (mux_sel == SEL_END) begin
`ifdef MUX8X1_SERIALIZER_PARITY_EN
            state_nxt = S_PARITY;
`else
            word_done = 1'b1;
`endif
          end else begin
            sel_nxt = MSB_FIRST ? (mux_sel - 3'd1) : (mux_sel + 3'd1);
          end
        end
      end
`ifdef MUX8X1_SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (out_ready) begin
          word_done = 1'b1;
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // With no gap, a waiting word is taken on the final beat so the stream
    // continues without a bubble.
    if (word_done) begin
      if (GAP > 0) begin
        state_nxt   = S_GAP;
        gap_cnt_nxt = GAP_LOAD;
      end else if (in_valid) begin
        data_nxt  = in_data;
        sel_nxt   = SEL_START;
        state_nxt = S_SHIFT;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  // Registered flag values derived from where the FSM is heading.
  always_comb begin
    bit_valid_nxt = (state_nxt == S_SHIFT);
`ifdef MUX8X1_SERIALIZER_PARITY_EN
    bit_valid_nxt = bit_valid_nxt || (state_nxt == S_PARITY);
    bit_last_nxt  = (state_nxt == S_PARITY);
`else
    bit_last_nxt  = (state_nxt == S_SHIFT) && (sel_nxt == SEL_END);
`endif
    busy_nxt = (state_nxt != S_IDLE);
  end

  assign in_ready = !rst && ((state == S_IDLE) || ((GAP == 0) && word_done));

`ifdef MUX8X1_SERIALIZER_PARITY_EN
  assign parity = ^mux_in;
`else
  assign parity = 1'b0;
`endif

endmodule
